// File: rtl/dire_straits_arb_if.sv
// rtl/dire_straits_arb_if.sv - requester/response handshake bundle for dire_straits_arb
interface dire_straits_arb_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [3:0] req0_and;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [3:0] req1_and;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_a_e;
  logic [3:0] rsp_b_e;
  logic [3:0] rsp_c_e;

  modport master (
    output req0_valid, req0_a, req0_b, req0_and,
    output req1_valid, req1_a, req1_b, req1_and,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_a_e, rsp_b_e, rsp_c_e
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_and,
    input  req1_valid, req1_a, req1_b, req1_and,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_a_e, rsp_b_e, rsp_c_e
  );
endinterface

// File: rtl/dire_straits_arb.sv
// rtl/dire_straits_arb.sv - two-requester arbiter/sequencer around one shared dire_straits evaluator
module dire_straits (
  input  logic [3:0] i_a_out,
  input  logic [3:0] i_b_out,
  input  logic [3:0] i_and_out,
  output logic [3:0] o_a_e,
  output logic [3:0] o_b_e,
  output logic [3:0] o_c_e
);
  logic [4:0] w_sum;

  assign w_sum = {1'b0, i_a_out} + {1'b0, i_b_out};
  assign o_a_e = w_sum[3:0];
  // carry out of the A+B sum selects whether the AND term passes through inverted
  assign o_b_e = w_sum[4] ? ~i_and_out : i_and_out;
  assign o_c_e = ~i_and_out;
endmodule

module dire_straits_arb #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  dire_straits_arb_if.slave bus,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_prio;
  logic             r_op_id;
  logic [3:0]       r_op_a;
  logic [3:0]       r_op_b;
  logic [3:0]       r_op_and;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [3:0]       r_rsp_a_e;
  logic [3:0]       r_rsp_b_e;
  logic [3:0]       r_rsp_c_e;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic             w_gnt_any;
  logic             w_gnt;
  logic             w_accept;
  logic             w_rsp_done;
  logic [3:0]       w_a_e;
  logic [3:0]       w_b_e;
  logic [3:0]       w_c_e;

  always_comb begin
    w_gnt_any = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) w_gnt = r_prio;
    else                                  w_gnt = bus.req1_valid;
  end

  assign w_accept       = (r_state == IDLE) && w_gnt_any;
  assign w_rsp_done     = (r_state == HOLD) && bus.rsp_ready;
  assign bus.req0_ready = w_accept && !w_gnt;
  assign bus.req1_ready = w_accept && w_gnt;

  dire_straits u_ds (
    .i_a_out   (r_op_a),
    .i_b_out   (r_op_b),
    .i_and_out (r_op_and),
    .o_a_e     (w_a_e),
    .o_b_e     (w_b_e),
    .o_c_e     (w_c_e)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_next = EVAL;
      EVAL:                    w_next = HOLD;
      HOLD:    if (w_rsp_done) w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio      <= 1'b0;
      r_op_id     <= 1'b0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_and    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_a_e   <= '0;
      r_rsp_b_e   <= '0;
      r_rsp_c_e   <= '0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      if (w_accept) begin
        r_op_a   <= w_gnt ? bus.req1_a   : bus.req0_a;
        r_op_b   <= w_gnt ? bus.req1_b   : bus.req0_b;
        r_op_and <= w_gnt ? bus.req1_and : bus.req0_and;
        r_op_id  <= w_gnt;
        r_prio   <= ~w_gnt;
      end
      if (r_state == EVAL) begin
        r_rsp_a_e   <= w_a_e;
        r_rsp_b_e   <= w_b_e;
        r_rsp_c_e   <= w_c_e;
        r_rsp_id    <= r_op_id;
        r_rsp_valid <= 1'b1;
      end
      if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
        if (r_op_id) r_cnt1 <= r_cnt1 + CNT_W'(1);
        else         r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_a_e   = r_rsp_a_e;
  assign bus.rsp_b_e   = r_rsp_b_e;
  assign bus.rsp_c_e   = r_rsp_c_e;
  assign cnt0          = r_cnt0;
  assign cnt1          = r_cnt1;
  assign busy          = (r_state != IDLE);
endmodule
